// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the sequential BCD add/sub
//               block: FSM state encoding, BCD digit limit and the decimal
//               correction constant.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADD   = 3'd2,
        ST_NEG   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Largest legal BCD digit value
    localparam logic [3:0] BCD_MAX  = 4'd9;
    // Added to a binary digit sum above 9 to skip the six unused codes
    localparam logic [3:0] BCD_CORR = 4'd6;

    // Nine's complement of one BCD digit
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seq_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_addsub_if
// Description : Request/result bundle of the sequential BCD add/sub block.
//               The master issues requests, the slave (the block) returns
//               status and results.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_seq_addsub_if #(
    parameter int DIGITS = 4
) ();

    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  neg;
    logic                  invalid;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, neg, invalid
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, neg, invalid
    );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : Single-digit combinational BCD adder. Both inputs are
//               assumed to be legal digits (0..9), so the binary sum never
//               exceeds 19 and one +6 correction always suffices.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import bcd_pkg::*;
(
    input  wire logic [3:0] i_a,
    input  wire logic [3:0] i_b,
    input  wire logic       i_cin,
    output logic      [3:0] o_sum,
    output logic            o_cout
);

    logic [4:0] w_bin;

    assign w_bin = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

    // Decimal correction: binary sums above 9 wrap by adding 6 and carry out
    always_comb begin
        if (w_bin > {1'b0, BCD_MAX}) begin
            o_sum  = w_bin[3:0] + BCD_CORR;
            o_cout = 1'b1;
        end else begin
            o_sum  = w_bin[3:0];
            o_cout = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_addsub
// Description : Digit-serial BCD adder/subtractor. Operands are latched on
//               start, checked for illegal digits, then processed one digit
//               per cycle (LSD first) through a single digit adder. A
//               negative difference is converted to its magnitude with a
//               second digit-serial ten's complement pass.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seq_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bcd_seq_addsub_if.slave   bus
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic            r_sub;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            r_cout_int;
    logic            r_neg_int;
    logic            r_inv_int;

    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_neg;
    logic            r_invalid;

    logic            w_bad;
    logic [3:0]      w_da;
    logic [3:0]      w_db;
    logic [3:0]      w_dig;
    logic            w_co;
    logic [W-1:0]    w_acc_shift;

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.neg     = r_neg;
    assign bus.invalid = r_invalid;

    // Flag any latched nibble of either operand that is not a decimal digit
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((r_a[4*i +: 4] > BCD_MAX) || (r_b[4*i +: 4] > BCD_MAX)) begin
                w_bad = 1'b1;
            end
        end
    end

    // Steer the shared digit adder: operand digits in ADD, complemented
    // partial result in NEG
    always_comb begin
        w_da = r_a[3:0];
        w_db = r_sub ? nines_comp(r_b[3:0]) : r_b[3:0];
        if (r_state == ST_NEG) begin
            w_da = nines_comp(r_acc[3:0]);
            w_db = 4'd0;
        end
    end

    bcd_digit_add u_digit (
        .i_a    (w_da),
        .i_b    (w_db),
        .i_cin  (r_carry),
        .o_sum  (w_dig),
        .o_cout (w_co)
    );

    // New digit enters at the top; after DIGITS shifts the result is aligned
    assign w_acc_shift = (r_acc >> 4) | (W'(w_dig) << (W - 4));

    // Control FSM with registered outputs and digit-serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_sub      <= 1'b0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_cout_int <= 1'b0;
            r_neg_int  <= 1'b0;
            r_inv_int  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_neg      <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_sub      <= bus.sub;
                        // Subtraction is a + nines(b) + 1
                        r_carry    <= bus.sub ? 1'b1 : bus.cin;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_cout_int <= 1'b0;
                        r_neg_int  <= 1'b0;
                        r_inv_int  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_idx <= '0;
                    if (w_bad) begin
                        r_inv_int <= 1'b1;
                        r_acc     <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_acc   <= w_acc_shift;
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_co;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_idx <= '0;
                        if (!r_sub) begin
                            r_cout_int <= w_co;
                            r_state    <= ST_DONE;
                        end else if (w_co) begin
                            r_state <= ST_DONE;
                        end else begin
                            // No end-around carry: result is the ten's
                            // complement of the magnitude
                            r_neg_int <= 1'b1;
                            r_carry   <= 1'b1;
                            r_state   <= ST_NEG;
                        end
                    end
                end
                ST_NEG: begin
                    r_acc   <= w_acc_shift;
                    r_carry <= w_co;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_sum     <= r_acc;
                    r_cout    <= r_cout_int;
                    r_neg     <= r_neg_int;
                    r_invalid <= r_inv_int;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
